// File: rtl/puf_challenger.sv
// puf_challenger: issues NUM_CHAL challenges to a parity-triggered PUF. Each challenge is
// evaluated REPEATS times. A per-bit majority vote is then offered on a valid/ready output.
// Optional feature: define PUF_CHAL_LFSR_EN to draw challenges from an 8-bit Fibonacci LFSR
// (x^8+x^6+x^5+x^4+1) instead of an incrementing counter.
module puf_challenger #(
    parameter int unsigned NUM_CHAL   = 16,
    parameter int unsigned REPEATS    = 5,
    parameter logic [7:0]  START_CHAL = 8'h01,
    parameter logic [31:0] TIMEOUT    = 32'h0A00_0000
) (
    input  logic       count_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       puf_done,
    input  logic [7:0] puf_response,
    output logic [7:0] challenge,
    output logic       puf_reset,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       timeout_err
);

`ifdef PUF_CHAL_LFSR_EN
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [7:0] SEED = (START_CHAL == 8'h00) ? 8'h01 : START_CHAL;
`else
    localparam logic [7:0] SEED = START_CHAL;
`endif

    localparam logic [8:0] LAST_IDX = 9'(NUM_CHAL - 1);
    localparam logic [3:0] REP_LAST = 4'(REPEATS - 1);
    localparam logic [3:0] HALF     = 4'(REPEATS / 2);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StAccum,
        StOutput
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      chal_q, chal_d;
    logic            prst_q, prst_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [7:0][3:0] vote_q, vote_d;
    logic [3:0]      rep_q, rep_d;
    logic [8:0]      idx_q, idx_d;
    logic [31:0]     tmo_q, tmo_d;
    logic [7:0]      new_chal;

    // Successor of the current challenge.
    function automatic logic [7:0] next_chal(input logic [7:0] c);
`ifdef PUF_CHAL_LFSR_EN
        return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
`else
        return c + 8'd1;
`endif
    endfunction

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge count_clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            chal_q  <= SEED;
            prst_q  <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            vote_q  <= '0;
            rep_q   <= 4'd0;
            idx_q   <= 9'd0;
            tmo_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            chal_q  <= chal_d;
            prst_q  <= prst_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            vote_q  <= vote_d;
            rep_q   <= rep_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state logic. The challenge/puf_reset pair is updated on the transition into
    // ISSUE so that ISSUE itself presents a flipped parity and kicks the PUF off.
    always_comb begin
        state_d  = state_q;
        chal_d   = chal_q;
        prst_d   = prst_q;
        data_d   = data_q;
        valid_d  = valid_q;
        err_d    = err_q;
        vote_d   = vote_q;
        rep_d    = rep_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        new_chal = next_chal(chal_q);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    err_d   = 1'b0;
                    idx_d   = 9'd0;
                    rep_d   = 4'd0;
                    vote_d  = '0;
                    chal_d  = SEED;
                    // Toggle puf_reset only if the challenge alone would not flip parity.
                    prst_d  = prst_q ^ ((^SEED) == (^chal_q));
                end
            end
            StIssue: begin
                tmo_d   = 32'd0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                tmo_d = tmo_q + 32'd1;
                if (!puf_done) begin
                    state_d = StWaitDone;
                end else if (tmo_d >= TIMEOUT) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StWaitDone: begin
                tmo_d = tmo_q + 32'd1;
                // Completion takes priority over a timeout reached in the same cycle.
                if (puf_done) begin
                    state_d = StAccum;
                end else if (tmo_d >= TIMEOUT) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StAccum: begin
                for (int i = 0; i < 8; i++) begin
                    vote_d[i] = vote_q[i] + {3'b000, puf_response[i]};
                end
                if (rep_q == REP_LAST) begin
                    state_d = StOutput;
                    valid_d = 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        data_d[i] = (vote_d[i] > HALF);
                    end
                end else begin
                    // Repeat evaluation: same challenge, parity flipped via puf_reset.
                    rep_d   = rep_q + 4'd1;
                    prst_d  = ~prst_q;
                    state_d = StIssue;
                end
            end
            StOutput: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    vote_d  = '0;
                    rep_d   = 4'd0;
                    idx_d   = idx_q + 9'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StIssue;
                        chal_d  = new_chal;
                        prst_d  = prst_q ^ ((^new_chal) == (^chal_q));
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign challenge   = chal_q;
    assign puf_reset   = prst_q;
    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign timeout_err = err_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: doc/puf_challenger.md
PUF_CHALLENGER -- requirements
Module: puf_challenger

Interface
REQ-001 SHALL have parameter NUM_CHAL, default 16, giving the number of challenges issued per start (1..256).
REQ-002 SHALL have parameter REPEATS, default 5, giving the PUF evaluations per challenge for the majority vote (odd, 1..15).
REQ-003 SHALL have parameter START_CHAL, default 8'h01, giving the first challenge (counter mode) or the LFSR seed.
REQ-004 SHALL have parameter TIMEOUT, default 32'h0A00_0000, giving the maximum count_clk cycles per evaluation.
REQ-005 SHALL have ports, clock and reset first:
- count_clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin a run; sampled in IDLE only.
- puf_done  in  1  PUF idle/complete flag.
- puf_response  in  8  PUF response, valid while puf_done=1.
- challenge  out  8  challenge driven to the PUF.
- puf_reset  out  1  parity-toggle line to the PUF reset input.
- out_data  out  8  majority-voted response.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  run in progress.
- timeout_err  out  1  sticky evaluation timeout flag.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACCUM, OUTPUT.
REQ-007 IDLE -> ISSUE when start=1; this transition SHALL clear timeout_err, the challenge index, and the vote counters.
REQ-008 ISSUE SHALL last 1 cycle and drive the challenge (new or repeated) so that ^{puf_reset, challenge} differs from its previous registered value, because the PUF starts only on a parity change.
REQ-009 For a new challenge whose parity equals the old one, ISSUE SHALL toggle puf_reset; for a repeat evaluation, ISSUE SHALL toggle puf_reset only.
REQ-010 WAIT_BUSY -> WAIT_DONE on the first cycle with puf_done=0.
REQ-011 WAIT_DONE -> ACCUM on the first cycle with puf_done=1; ACCUM SHALL sample puf_response in that cycle.
REQ-012 ACCUM SHALL increment one 4-bit vote counter per response bit whose bit is 1.
- If fewer than REPEATS samples have been taken, ACCUM SHALL go to ISSUE (repeat).
- Otherwise ACCUM SHALL go to OUTPUT.
REQ-013 On entry to OUTPUT, out_data[i] SHALL be 1 iff vote[i] > REPEATS/2 (integer division), and out_valid SHALL be 1.
REQ-014 out_valid and out_data SHALL be held stable until the cycle with out_ready=1; the transfer completes in that cycle, with no combinational path from out_ready to out_valid.
REQ-015 After a transfer, the FSM SHALL clear the vote counters, advance the challenge index, and go to ISSUE, or to IDLE after NUM_CHAL transfers.
REQ-016 In counter mode, challenge k SHALL be (START_CHAL + k) mod 256; the 8-bit wrap is legal.
REQ-017 A 32-bit timeout counter SHALL clear in ISSUE and increment in WAIT_BUSY/WAIT_DONE.
- When the count reaches TIMEOUT, the FSM SHALL set timeout_err=1, abort to IDLE, and assert no out_valid for that challenge.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 If puf_done rises in the same cycle the timeout count is reached, completion SHALL win.

Reset
REQ-021 Asserting reset at any time, including mid-run, SHALL immediately force all of the following, with no transfer completing:
- state=IDLE.
- challenge=START_CHAL (8'h01 if START_CHAL=0 in LFSR mode).
- puf_reset=0.
- out_data=0, out_valid=0, busy=0, timeout_err=0.
- vote and timeout counters=0.
REQ-022 Release of reset SHALL take effect on the next count_clk edge; no start is accepted while reset=1.

Configuration
REQ-023 With macro PUF_CHAL_LFSR_EN defined, challenges SHALL come from an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shifting left.
- Seed SHALL be START_CHAL (8'h01 if zero).
- The LFSR SHALL advance once per new challenge.
REQ-024 Without PUF_CHAL_LFSR_EN, the counter sequence of REQ-016 SHALL be used; no LFSR logic SHALL be synthesised.

Verification
REQ-025 Counter mode, NUM_CHAL=3, REPEATS=1, PUF model returns ~challenge -> out_data 8'hFE, 8'hFD, 8'hFC, then busy=0.
REQ-026 REPEATS=5, model returns 8'hA5 three times and 8'h5A twice for one challenge -> out_data=8'hA5.
REQ-027 Challenge step 8'h01->8'h02 (equal parity) -> puf_reset toggles in ISSUE; PUF model restarts within 2 cycles.
REQ-028 PUF model holds puf_done=0, TIMEOUT=100 -> timeout_err=1 and IDLE 100 cycles after ISSUE; out_valid never asserted.
REQ-029 out_ready held 0 for 50 cycles -> out_valid and out_data stable throughout; exactly one transfer when out_ready rises.
REQ-030 reset pulsed in WAIT_DONE -> all outputs at reset values in the same cycle; a new start then begins from START_CHAL.
